csa_accum_resolve: RTL and testbench

CSA_ACCUM_RESOLVE -- requirements
Module: csa_accum_resolve

---
 rtl/csa_accum_pkg.sv | 18 +
 rtl/csa_split_adder.sv | 62 ++++++
 rtl/csa_accum_resolve.sv | 110 +++++++++++
 tb/tb_csa_accum_resolve.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_accum_pkg.sv
// Shared constants and width helpers for the carry-save accumulate/resolve block.
package csa_accum_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_FRAME_LEN = 4;

    // Width of the low half resolved in the first adder stage.
    function automatic int half_w(input int width);
        return width / 2;
    endfunction

    // Frame counter width; a one-pair frame still gets a 1-bit counter.
    function automatic int cnt_w(input int frame_len);
        return (frame_len <= 1) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/csa_split_adder.sv
// Two-stage carry-propagate adder that resolves a carry-save pair into a
// WIDTH+1 bit value: low half in stage 1, high half plus carry in stage 2.
// en_i freezes both stages (data and valids) when downstream stalls.
module csa_split_adder
    import csa_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] carry_i,
    output logic             vld_o,
    output logic [WIDTH:0]   res_o
);

    localparam int H  = half_w(WIDTH);
    localparam int HH = WIDTH - H;

    // Stage 1: resolved low half with its carry-out, high halves still split.
    logic [H-1:0]  lo_q;
    logic          c1_q;
    logic [HH-1:0] hs_q, hc_q;
    // Stage 2: fully resolved value.
    logic [WIDTH:0] res_q;
    // Valid shift register: [0] = stage 1, [1] = stage 2.
    logic [1:0]     vld_q;

    logic [H:0]  lo_d;
    logic [HH:0] hi_d;

    // Combinational halves of the two adder stages.
    always_comb begin
        lo_d = {1'b0, sum_i[H-1:0]} + {1'b0, carry_i[H-1:0]};
        hi_d = {1'b0, hs_q} + {1'b0, hc_q} + (HH+1)'(c1_q);
    end

    // Pipeline registers; everything holds while en_i is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            lo_q  <= '0;
            c1_q  <= 1'b0;
            hs_q  <= '0;
            hc_q  <= '0;
            res_q <= '0;
        end else if (en_i) begin
            vld_q <= {vld_q[0], vld_i};
            lo_q  <= lo_d[H-1:0];
            c1_q  <= lo_d[H];
            hs_q  <= sum_i[WIDTH-1:H];
            hc_q  <= carry_i[WIDTH-1:H];
            res_q <= {hi_d, lo_q};
        end
    end

    assign vld_o = vld_q[1];
    assign res_o = res_q;

endmodule

// File: rtl/csa_accum_resolve.sv
// Resolves carry-save pairs and sums FRAME_LEN of them per output result,
// with a sticky overflow flag and a one-deep output register under
// ready/valid backpressure.
module csa_accum_resolve
    import csa_accum_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     IN_SUM,
    input  logic [WIDTH-1:0]     IN_CARRY,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ACC_WIDTH-1:0] OUT_SUM,
    output logic                 OUT_OVF
);

    localparam int                CW       = cnt_w(FRAME_LEN);
    localparam logic [CW-1:0]     CNT_LAST = CW'(FRAME_LEN - 1);

    logic                 hold;
    logic                 r_vld;
    logic [WIDTH:0]       r_val;
    logic [ACC_WIDTH:0]   add_w;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                 out_ovf_q, out_ovf_d;
    logic                 out_valid_q, out_valid_d;

    // A result waiting on a not-ready consumer freezes the whole pipe; the
    // input ready therefore depends combinationally on OUT_READY.
    assign hold     = out_valid_q && !OUT_READY;
    assign IN_READY = !hold;

    csa_split_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (!hold),
        .vld_i   (IN_VALID && !hold),
        .sum_i   (IN_SUM),
        .carry_i (IN_CARRY),
        .vld_o   (r_vld),
        .res_o   (r_val)
    );

    // Accumulator add with carry-out kept for overflow tracking.
    assign add_w = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(r_val)};

    // Next-state for accumulator, frame counter and output register.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (!hold) begin
            // Not holding, so a valid output here is being accepted.
            if (out_valid_q) out_valid_d = 1'b0;
            if (r_vld) begin
                if (cnt_q == CNT_LAST) begin
                    out_sum_d   = add_w[ACC_WIDTH-1:0];
                    out_ovf_d   = sticky_q | add_w[ACC_WIDTH];
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sticky_d    = 1'b0;
                end else begin
                    acc_d    = add_w[ACC_WIDTH-1:0];
                    cnt_d    = cnt_q + CW'(1);
                    sticky_d = sticky_q | add_w[ACC_WIDTH];
                end
            end
        end
    end

    // State registers; reset wins over everything on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_SUM   = out_sum_q;
    assign OUT_OVF   = out_ovf_q;

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Bench: three instances (FRAME_LEN=1, default, ACC_WIDTH=9) share one input
// stream; each has its own frame-sum reference model and result log.
module tb_csa_accum_resolve;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic [7:0] IN_SUM = '0, IN_CARRY = '0;
    logic       OUT_READY = 1'b1;
    logic       rnd_rdy = 1'b0;

    logic [2:0]  ov, ovf, ir;
    logic [15:0] os [3];
    logic [15:0] s_f1, s_f4;
    logic [8:0]  s_a9;

    int total = 0;
    int bad   = 0;

    int FL [3] = '{1, 4, 4};
    int AW [3] = '{16, 16, 9};

    longint      tot [3];
    int          cnt [3];
    logic [16:0] expq [3][$];
    logic [16:0] logq [3][$];
    logic [2:0]  held_prev;
    logic [15:0] prev_s [3];
    logic [2:0]  prev_o;

    always #5 clk = ~clk;

    csa_accum_resolve #(.WIDTH(8), .ACC_WIDTH(16), .FRAME_LEN(1)) u_f1 (
        .CLK(clk), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[0]),
        .IN_SUM(IN_SUM), .IN_CARRY(IN_CARRY), .OUT_VALID(ov[0]),
        .OUT_READY(OUT_READY), .OUT_SUM(s_f1), .OUT_OVF(ovf[0]));

    csa_accum_resolve #(.WIDTH(8), .ACC_WIDTH(16), .FRAME_LEN(4)) u_f4 (
        .CLK(clk), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[1]),
        .IN_SUM(IN_SUM), .IN_CARRY(IN_CARRY), .OUT_VALID(ov[1]),
        .OUT_READY(OUT_READY), .OUT_SUM(s_f4), .OUT_OVF(ovf[1]));

    csa_accum_resolve #(.WIDTH(8), .ACC_WIDTH(9), .FRAME_LEN(4)) u_a9 (
        .CLK(clk), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[2]),
        .IN_SUM(IN_SUM), .IN_CARRY(IN_CARRY), .OUT_VALID(ov[2]),
        .OUT_READY(OUT_READY), .OUT_SUM(s_a9), .OUT_OVF(ovf[2]));

    always_comb begin
        os[0] = s_f1;
        os[1] = s_f4;
        os[2] = {7'd0, s_a9};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: each instance sums the pairs it actually accepted; every
    // FRAME_LEN pairs produce (total mod 2^AW, total >= 2^AW).
    always @(negedge clk) begin
        if (RST) begin
            for (int d = 0; d < 3; d++) begin
                tot[d] = 0;
                cnt[d] = 0;
                expq[d].delete();
            end
            held_prev = '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("in_ready%0d", d), ir[d], !(ov[d] && !OUT_READY));
                if (held_prev[d] && ov[d]) begin
                    chk($sformatf("stable_sum%0d", d), os[d], prev_s[d]);
                    chk($sformatf("stable_ovf%0d", d), ovf[d], prev_o[d]);
                end
                if (ov[d] && OUT_READY) begin
                    if (expq[d].size() == 0) begin
                        chk($sformatf("unexpected_out%0d", d), expq[d].size(), 1);
                    end else begin
                        logic [16:0] e;
                        e = expq[d].pop_front();
                        chk($sformatf("sum%0d", d), os[d], e[15:0]);
                        chk($sformatf("ovf%0d", d), ovf[d], e[16]);
                    end
                    logq[d].push_back({ovf[d], os[d]});
                end
                held_prev[d] = ov[d] && !OUT_READY;
                prev_s[d]    = os[d];
                prev_o[d]    = ovf[d];
                if (IN_VALID && ir[d]) begin
                    tot[d] += longint'(IN_SUM) + longint'(IN_CARRY);
                    cnt[d]++;
                    if (cnt[d] == FL[d]) begin
                        longint lim;
                        lim = longint'(1) << AW[d];
                        expq[d].push_back({tot[d] >= lim, 16'(tot[d] % lim)});
                        tot[d] = 0;
                        cnt[d] = 0;
                    end
                end
            end
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            if (rnd_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
        end
    end

    // Hold a pair until the default instance accepts it.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int   t;
        logic r;
        t = 0;
        IN_VALID = 1'b1;
        IN_SUM   = a;
        IN_CARRY = b;
        forever begin
            @(negedge clk);
            r = ir[1];
            @(posedge clk);
            #1;
            if (r) break;
            t++;
            if (t > 200) begin
                chk("send_timeout", t, 0);
                break;
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid%0d", d), ov[d], 0);
            chk($sformatf("rst_sum%0d", d), os[d], 0);
            chk($sformatf("rst_ovf%0d", d), ovf[d], 0);
            chk($sformatf("rst_ready%0d", d), ir[d], 1);
            logq[d].delete();
        end
    endtask

    task automatic frame_a(input int gaps);
        logic [7:0] a [4] = '{8'h10, 8'h0F, 8'hFF, 8'h00};
        logic [7:0] b [4] = '{8'h20, 8'h01, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            send(a[i], b[i]);
            if (gaps != 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic frame_ones();
        for (int i = 0; i < 4; i++) send(8'h01, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single-pair frame: latency and carry across the half boundary.
        send(8'hFF, 8'h01);
        chk("lat_e0", ov[0], 0);
        @(posedge clk); #1;
        chk("lat_e1", ov[0], 0);
        @(posedge clk); #1;
        chk("lat_e2", ov[0], 1);
        chk("lat_sum", os[0], 16'h0100);
        chk("lat_ovf", ovf[0], 0);
        idle(6);

        // Back-to-back frame, one result pulse.
        do_reset();
        frame_a(0);
        idle(8);
        chk("b2b_count", logq[1].size(), 1);
        if (logq[1].size() >= 1) chk("b2b_sum", logq[1][0], {1'b0, 16'h023E});

        // Same frame with input gaps.
        do_reset();
        frame_a(1);
        idle(8);
        chk("gap_count", logq[1].size(), 1);
        if (logq[1].size() >= 1) chk("gap_sum", logq[1][0], {1'b0, 16'h023E});

        // Backpressure across two frames.
        do_reset();
        OUT_READY = 1'b0;
        frame_a(0);
        fork
            frame_ones();
            begin
                repeat (12) begin @(posedge clk); #1; end
                chk("bp_ready_low", ir[1], 0);
                chk("bp_hold_sum", os[1], 16'h023E);
                chk("bp_hold_valid", ov[1], 1);
                OUT_READY = 1'b1;
            end
        join
        idle(10);
        chk("bp_count", logq[1].size(), 2);
        if (logq[1].size() >= 2) begin
            chk("bp_first", logq[1][0], {1'b0, 16'h023E});
            chk("bp_second", logq[1][1], {1'b0, 16'h0004});
        end

        // Narrow accumulator overflow, then a clean frame.
        do_reset();
        for (int i = 0; i < 4; i++) send(8'hFF, 8'hFF);
        frame_ones();
        idle(8);
        chk("ovf_count", logq[2].size(), 2);
        if (logq[2].size() >= 2) begin
            chk("ovf_first", logq[2][0], {1'b1, 16'h01F8});
            chk("ovf_second", logq[2][1], {1'b0, 16'h0004});
        end

        // Reset mid-frame drops partial frame and in-flight pairs.
        do_reset();
        send(8'h12, 8'h34);
        send(8'h56, 8'h78);
        RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        frame_ones();
        idle(8);
        chk("midrst_count", logq[1].size(), 1);
        if (logq[1].size() >= 1) chk("midrst_sum", logq[1][0], {1'b0, 16'h0004});

        // Random pairs, gaps and consumer backpressure.
        do_reset();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        OUT_READY = 1'b1;
        idle(12);
        for (int d = 0; d < 3; d++)
            chk($sformatf("leftover%0d", d), expq[d].size(), 0);
        chk("rnd_results_f4", (logq[1].size() > 10), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
